// File: rtl/switch_mcu_pkg.sv
// switch_mcu_pkg: shared state, fault and instruction constants for the switch MCU front end
package switch_mcu_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_TIMEOUT  = 2'd2,
    FAULT_BUSERR   = 2'd3
  } fault_t;
endpackage

// File: rtl/switch_mcu_fetch_if.sv
// switch_mcu_fetch_if: sequencing controls, instruction-memory bus and decoder-facing outputs
interface switch_mcu_fetch_if;
  import switch_mcu_pkg::*;
  logic              in_stall;
  logic              in_pc_load;
  logic [31:0]       in_pc_target;
  logic              out_mem_req;
  logic [31:0]       out_mem_addr;
  logic              in_mem_ready;
  logic [INST_W-1:0] in_mem_rdata;
  logic              in_mem_err;
  logic [INST_W-1:0] out_inst;
  logic [31:0]       out_pc;
  logic [3:0]        out_cycle_cnt;
  logic              out_halt;
  logic [1:0]        out_fault_code;
  modport master (
    input  in_stall, in_pc_load, in_pc_target, in_mem_ready, in_mem_rdata, in_mem_err,
    output out_mem_req, out_mem_addr, out_inst, out_pc, out_cycle_cnt, out_halt, out_fault_code
  );
  modport slave (
    output in_stall, in_pc_load, in_pc_target, in_mem_ready, in_mem_rdata, in_mem_err,
    input  out_mem_req, out_mem_addr, out_inst, out_pc, out_cycle_cnt, out_halt, out_fault_code
  );
endinterface

// File: rtl/switch_mcu_fetch_timer.sv
// switch_mcu_fetch_timer: counts consecutive unanswered request cycles and flags expiry
module switch_mcu_fetch_timer #(
  parameter logic [7:0] LIMIT = 8'd64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [7:0] cnt_q;
  // clear wins over counting so a stall or an accept restarts the window
  always_ff @(posedge clk_i)
    cnt_q <= (rst_i || clr_i) ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  assign expire_o = en_i && cnt_q == LIMIT - 8'd1;
endmodule

// File: rtl/switch_mcu_fetch.sv
// switch_mcu_fetch: PC owner, single-word fetcher and per-instruction cycle sequencer
module switch_mcu_fetch
  import switch_mcu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [3:0]  CYC_LAST    = 4'd5,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd64
) (
  input logic in_clk,
  input logic in_rst,
  switch_mcu_fetch_if.master bus
);
  state_t            state_q, state_d;
  fault_t            fault_q, fault_d;
  logic [31:0]       pc_q, pc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              req, accept, expire, misalign;
  assign req      = state_q == FETCH && !bus.in_stall && !in_rst;
  assign accept   = req && bus.in_mem_ready;
  assign misalign = bus.in_pc_load && bus.in_pc_target[1:0] != 2'b00;
  switch_mcu_fetch_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk_i    (in_clk),
    .rst_i    (in_rst),
    .clr_i    (!req || bus.in_mem_ready),
    .en_i     (req && !bus.in_mem_ready),
    .expire_o (expire)
  );
  // next state: faults first, then stall hold, then normal sequencing
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    case (state_q)
      FETCH: begin
        if (accept && bus.in_mem_err) begin
          state_d = HALT;
          fault_d = FAULT_BUSERR;
        end else if (accept) begin
          state_d = EXEC;
          inst_d  = bus.in_mem_rdata;
          cnt_d   = 4'd1;
        end else if (expire) begin
          state_d = HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      EXEC: begin
        if (!bus.in_stall && cnt_q == CYC_LAST) begin
          cnt_d   = 4'd0;
          state_d = misalign ? HALT : FETCH;
          fault_d = misalign ? FAULT_MISALIGN : fault_q;
          pc_d    = misalign ? pc_q : bus.in_pc_load ? bus.in_pc_target : pc_q + 32'd4;
        end else if (!bus.in_stall) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: cnt_d = 4'd0;
    endcase
  end
  // state register with synchronous reset overriding everything
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= FETCH;
      fault_q <= FAULT_NONE;
      pc_q    <= RESET_PC;
      cnt_q   <= 4'd0;
      inst_q  <= NOP;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
    end
  end
  assign bus.out_mem_req    = req;
  assign bus.out_mem_addr   = pc_q;
  assign bus.out_pc         = pc_q;
  assign bus.out_inst       = inst_q;
  assign bus.out_cycle_cnt  = cnt_q;
  assign bus.out_halt       = state_q == HALT;
  assign bus.out_fault_code = fault_q;
endmodule

// File: tb/tb_switch_mcu_fetch.sv
// tb_switch_mcu_fetch: directed scenarios plus randomized traffic against a behavioural model
module tb_switch_mcu_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] RST_PC_B = 32'hFFFF_FFFC;
  localparam logic [3:0] LAST = 4'd5;
  localparam int TMO = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] m_pc, m_inst;
  logic [3:0] m_cnt;
  logic m_halt;
  logic [1:0] m_fault;
  int m_wait;
  always #5 clk = ~clk;
  switch_mcu_fetch_if ifa ();
  switch_mcu_fetch_if ifb ();
  assign ifb.in_stall     = ifa.in_stall;
  assign ifb.in_pc_load   = ifa.in_pc_load;
  assign ifb.in_pc_target = ifa.in_pc_target;
  assign ifb.in_mem_ready = ifa.in_mem_ready;
  assign ifb.in_mem_rdata = ifa.in_mem_rdata;
  assign ifb.in_mem_err   = ifa.in_mem_err;
  switch_mcu_fetch #(.RESET_PC(RST_PC), .CYC_LAST(LAST), .MEM_TIMEOUT(8'd64)) dut_a (
    .in_clk(clk), .in_rst(rst), .bus(ifa)
  );
  switch_mcu_fetch #(.RESET_PC(RST_PC_B), .CYC_LAST(LAST), .MEM_TIMEOUT(8'd64)) dut_b (
    .in_clk(clk), .in_rst(rst), .bus(ifb)
  );
  function automatic logic m_req();
    return !rst && !m_halt && m_cnt == 4'd0 && !ifa.in_stall;
  endfunction
  task automatic drive(input logic s, input logic r, input logic [31:0] d, input logic e,
                       input logic p, input logic [31:0] t);
    ifa.in_stall = s;
    ifa.in_mem_ready = r;
    ifa.in_mem_rdata = d;
    ifa.in_mem_err = e;
    ifa.in_pc_load = p;
    ifa.in_pc_target = t;
  endtask
  task automatic tick();
    logic [31:0] tgt;
    tgt = ifa.in_pc_target;
    if (rst) begin
      m_pc = RST_PC; m_inst = 32'h0000_0013; m_cnt = 4'd0; m_halt = 1'b0; m_fault = 2'd0; m_wait = 0;
    end else if (!m_halt && m_cnt == 4'd0) begin
      if (!m_req()) m_wait = 0;
      else if (ifa.in_mem_ready) begin
        m_wait = 0;
        if (ifa.in_mem_err) begin m_halt = 1'b1; m_fault = 2'd3; end
        else begin m_inst = ifa.in_mem_rdata; m_cnt = 4'd1; end
      end else if (m_wait == TMO - 1) begin m_halt = 1'b1; m_fault = 2'd2; end
      else m_wait++;
    end else if (!m_halt && !ifa.in_stall) begin
      if (m_cnt != LAST) m_cnt = m_cnt + 4'd1;
      else begin
        m_cnt = 4'd0;
        if (ifa.in_pc_load && tgt[1:0] != 2'b00) begin m_halt = 1'b1; m_fault = 2'd1; end
        else m_pc = ifa.in_pc_load ? tgt : m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_cnt(input logic [3:0] n);
    for (int i = 0; i < 40 && m_cnt != n; i++) tick();
    total++;
    if (ifa.out_cycle_cnt !== n) begin bad++; $display("FAIL wait_cnt act=%0d exp=%0d", ifa.out_cycle_cnt, n); end
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0);
    #1;
    total++;
    if (ifa.out_mem_req !== 1'b0 || ifb.out_mem_req !== 1'b0) begin bad++; $display("FAIL reset_req act=%b%b exp=00", ifa.out_mem_req, ifb.out_mem_req); end
    tick();
    tick();
    total++;
    if (ifa.out_pc !== RST_PC || ifa.out_cycle_cnt !== 4'd0 || ifa.out_inst !== 32'h0000_0013)
      begin bad++; $display("FAIL reset_state pc=%h cnt=%0d inst=%h exp=%h 0 00000013", ifa.out_pc, ifa.out_cycle_cnt, ifa.out_inst, RST_PC); end
    total++;
    if (ifa.out_halt !== 1'b0 || ifa.out_fault_code !== 2'd0) begin bad++; $display("FAIL reset_halt halt=%b fault=%0d exp=0 0", ifa.out_halt, ifa.out_fault_code); end
    total++;
    if (ifb.out_pc !== RST_PC_B) begin bad++; $display("FAIL reset_pc_b act=%h exp=%h", ifb.out_pc, RST_PC_B); end
    rst = 1'b0;
    #1;
    total++;
    if (ifa.out_mem_req !== 1'b1) begin bad++; $display("FAIL req_after_reset act=%b exp=1", ifa.out_mem_req); end
  endtask
  task automatic test_basic();
    tick();
    total++;
    if (ifa.out_inst !== 32'h0010_0093 || ifa.out_cycle_cnt !== 4'd1) begin bad++; $display("FAIL first_inst inst=%h cnt=%0d exp=00100093 1", ifa.out_inst, ifa.out_cycle_cnt); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      total++;
      if (ifa.out_cycle_cnt !== 4'(k)) begin bad++; $display("FAIL cnt_step act=%0d exp=%0d", ifa.out_cycle_cnt, k); end
    end
    tick();
    total++;
    if (ifa.out_mem_addr !== 32'h0000_0004 || ifa.out_cycle_cnt !== 4'd0) begin bad++; $display("FAIL seq_addr addr=%h cnt=%0d exp=00000004 0", ifa.out_mem_addr, ifa.out_cycle_cnt); end
  endtask
  task automatic test_redirect();
    logic [31:0] base;
    base = m_pc;
    wait_cnt(4'd3);
    ifa.in_pc_load = 1'b1; ifa.in_pc_target = 32'h0000_0100;
    tick();
    ifa.in_pc_load = 1'b0;
    wait_cnt(4'd0);
    total++;
    if (ifa.out_mem_addr !== base + 32'd4) begin bad++; $display("FAIL ignored_load act=%h exp=%h", ifa.out_mem_addr, base + 32'd4); end
    wait_cnt(4'd5);
    ifa.in_pc_load = 1'b1; ifa.in_pc_target = 32'h0000_0100;
    tick();
    ifa.in_pc_load = 1'b0;
    total++;
    if (ifa.out_mem_addr !== 32'h0000_0100) begin bad++; $display("FAIL redirect act=%h exp=00000100", ifa.out_mem_addr); end
  endtask
  task automatic test_stall();
    logic [31:0] pc0;
    wait_cnt(4'd2);
    pc0 = ifa.out_pc;
    ifa.in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ifa.out_cycle_cnt !== 4'd2 || ifa.out_pc !== pc0) begin bad++; $display("FAIL exec_stall cnt=%0d pc=%h exp=2 %h", ifa.out_cycle_cnt, ifa.out_pc, pc0); end
    end
    ifa.in_stall = 1'b0;
    wait_cnt(4'd0);
    ifa.in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ifa.out_mem_req !== 1'b0 || ifa.out_cycle_cnt !== 4'd0) begin bad++; $display("FAIL fetch_stall req=%b cnt=%0d exp=0 0", ifa.out_mem_req, ifa.out_cycle_cnt); end
      tick();
    end
    ifa.in_stall = 1'b0; ifa.in_mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    ifa.in_stall = 1'b1;
    tick(); tick();
    ifa.in_stall = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    total++;
    if (ifa.out_halt !== 1'b0) begin bad++; $display("FAIL stall_clears_timer halt=%b exp=0", ifa.out_halt); end
    ifa.in_mem_ready = 1'b1;
    tick();
    total++;
    if (ifa.out_cycle_cnt !== 4'd1) begin bad++; $display("FAIL late_accept cnt=%0d exp=1", ifa.out_cycle_cnt); end
  endtask
  task automatic test_timeout();
    wait_cnt(4'd0);
    ifa.in_mem_ready = 1'b0;
    for (int i = 0; i < TMO - 1; i++) tick();
    total++;
    if (ifa.out_halt !== 1'b0) begin bad++; $display("FAIL timeout_early halt=%b exp=0", ifa.out_halt); end
    tick();
    total++;
    if (ifa.out_halt !== 1'b1 || ifa.out_fault_code !== 2'd2 || ifa.out_mem_req !== 1'b0)
      begin bad++; $display("FAIL timeout halt=%b fault=%0d req=%b exp=1 2 0", ifa.out_halt, ifa.out_fault_code, ifa.out_mem_req); end
    ifa.in_mem_ready = 1'b1;
    tick(); tick(); tick();
    total++;
    if (ifa.out_halt !== 1'b1 || ifa.out_mem_req !== 1'b0 || ifa.out_cycle_cnt !== 4'd0)
      begin bad++; $display("FAIL halt_sticky halt=%b req=%b cnt=%0d exp=1 0 0", ifa.out_halt, ifa.out_mem_req, ifa.out_cycle_cnt); end
    pulse_reset();
  endtask
  task automatic test_misalign();
    logic [31:0] pc0;
    drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    wait_cnt(4'd5);
    pc0 = ifa.out_pc;
    ifa.in_pc_load = 1'b1; ifa.in_pc_target = 32'h0000_0102;
    tick();
    ifa.in_pc_load = 1'b0;
    total++;
    if (ifa.out_halt !== 1'b1 || ifa.out_fault_code !== 2'd1 || ifa.out_pc !== pc0 || ifa.out_mem_req !== 1'b0)
      begin bad++; $display("FAIL misalign halt=%b fault=%0d pc=%h req=%b exp=1 1 %h 0", ifa.out_halt, ifa.out_fault_code, ifa.out_pc, ifa.out_mem_req, pc0); end
    pulse_reset();
  endtask
  task automatic test_bus_err();
    drive(1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0);
    tick();
    wait_cnt(4'd0);
    ifa.in_mem_err = 1'b1; ifa.in_mem_rdata = 32'hDEAD_BEEF;
    tick();
    total++;
    if (ifa.out_halt !== 1'b1 || ifa.out_fault_code !== 2'd3 || ifa.out_inst !== 32'hCAFE_0001)
      begin bad++; $display("FAIL bus_err halt=%b fault=%0d inst=%h exp=1 3 cafe0001", ifa.out_halt, ifa.out_fault_code, ifa.out_inst); end
    ifa.in_mem_err = 1'b0;
    pulse_reset();
  endtask
  task automatic test_wrap_and_reset();
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (ifb.out_mem_addr !== 32'h0 || ifb.out_pc !== 32'h0) begin bad++; $display("FAIL pc_wrap addr=%h pc=%h exp=00000000", ifb.out_mem_addr, ifb.out_pc); end
    ifa.in_mem_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (ifa.out_mem_req !== 1'b0 || ifb.out_mem_req !== 1'b0) begin bad++; $display("FAIL req_in_reset act=%b%b exp=00", ifa.out_mem_req, ifb.out_mem_req); end
    tick();
    rst = 1'b0;
    total++;
    if (ifa.out_pc !== RST_PC || ifb.out_pc !== RST_PC_B || ifa.out_cycle_cnt !== 4'd0 || ifb.out_cycle_cnt !== 4'd0)
      begin bad++; $display("FAIL mid_req_reset pc=%h/%h cnt=%0d/%0d exp=%h/%h 0/0", ifa.out_pc, ifb.out_pc, ifa.out_cycle_cnt, ifb.out_cycle_cnt, RST_PC, RST_PC_B); end
  endtask
  task automatic test_random();
    logic [103:0] act, exp;
    logic [31:0] tgt;
    for (int i = 0; i < 1500; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 60) == 0,
            $urandom_range(0, 3) == 0, tgt);
      rst = (m_halt && $urandom_range(0, 5) == 0) || $urandom_range(0, 200) == 0;
      #1;
      exp = {m_req(), m_pc, m_pc, m_inst, m_cnt, m_halt, m_fault};
      act = {ifa.out_mem_req, ifa.out_mem_addr, ifa.out_pc, ifa.out_inst, ifa.out_cycle_cnt, ifa.out_halt, ifa.out_fault_code};
      total++;
      if (act !== exp) begin bad++; $display("FAIL random cyc=%0d act=%h exp=%h", i, act, exp); end
      tick();
    end
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_redirect();
    test_stall();
    test_timeout();
    test_misalign();
    test_bus_err();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
